// File: rtl/mono_pkg.sv
// Shared hit-word layout and transmit FSM state encoding for the mono readout path.
package mono_pkg;

  localparam int HIT_WIDTH = 27;
  localparam int COL_W     = 6;
  localparam int COL_OFF   = 21;
  localparam int ROW_W     = 9;
  localparam int ROW_OFF   = 12;
  localparam int LE_W      = 6;
  localparam int LE_OFF    = 6;
  localparam int TE_W      = 6;
  localparam int TE_OFF    = 0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_t;

  function automatic logic [HIT_WIDTH-1:0] pack_hit(
    input logic [COL_W-1:0] col,
    input logic [ROW_W-1:0] row,
    input logic [LE_W-1:0]  le,
    input logic [TE_W-1:0]  te
  );
    logic [HIT_WIDTH-1:0] h;
    h = '0;
    h[COL_OFF +: COL_W] = col;
    h[ROW_OFF +: ROW_W] = row;
    h[LE_OFF  +: LE_W]  = le;
    h[TE_OFF  +: TE_W]  = te;
    return h;
  endfunction

endpackage

// File: rtl/mono_data_tx_fifo.sv
// Synchronous hit FIFO with show-ahead read port and occupancy count.
// Latency: pushed word visible on pop_dat the cycle after push; pop_dat always shows the head.
// Backpressure: push dropped when full unless a pop happens in the same cycle.
module mono_data_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/mono_data_tx.sv
// Buffers pixel hits and serialises one 27-bit word MSB-first per host read edge; optional MONO_DATA_TX_LOST_CNT_EN lost-hit counter.
// Latency: first bit on TX_DATA two cycles after the read edge is registered; 27*CLK_DIV cycles per word.
// Backpressure: hits dropped (and counted) when the buffer is full or TX_FREEZE is high.
module mono_data_tx
  import mono_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 HIT_WR,
  input  logic [HIT_WIDTH-1:0] HIT_DATA,
  output logic                 HIT_FULL,
  output logic                 TX_TOKEN,
  output logic                 TX_DATA,
  output logic                 TX_CLK,
  input  logic                 TX_READ,
  input  logic                 TX_FREEZE,
  output logic                 BUSY,
  output logic [7:0]           LOST_CNT
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BW   = $clog2(HIT_WIDTH);
  localparam int HALF = CLK_DIV / 2;

  tx_state_t            state;
  logic [HIT_WIDTH-1:0] shreg;
  logic [DIVW-1:0]      div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 read_q;
  logic                 read_edge;
  logic                 tx_data_r;
  logic                 tx_clk_r;
  logic                 busy_r;
  logic                 token_r;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [HIT_WIDTH-1:0] fifo_dat;
  logic                 pop;
  logic                 hit_acc;

  // The only pop happens in LOAD, which is entered only with a non-empty buffer.
  assign pop       = (state == TX_LOAD);
  assign hit_acc   = HIT_WR & ~TX_FREEZE & (~fifo_full | pop);
  assign read_edge = TX_READ & ~read_q;
  assign HIT_FULL  = (fifo_count == CW'(DEPTH));

  mono_data_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (HIT_WIDTH)
  ) u_fifo (
    .clk      (BUS_CLK),
    .rst      (BUS_RST),
    .push     (hit_acc),
    .push_dat (HIT_DATA),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= TX_IDLE;
      shreg     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      read_q    <= 1'b0;
      tx_data_r <= 1'b0;
      tx_clk_r  <= 1'b0;
      busy_r    <= 1'b0;
      token_r   <= 1'b0;
    end else begin
      read_q  <= TX_READ;
      token_r <= ~fifo_empty;
      case (state)
        TX_IDLE: begin
          if (read_edge && !fifo_empty) begin
            state  <= TX_LOAD;
            busy_r <= 1'b1;
          end
        end
        TX_LOAD: begin
          state     <= TX_SHIFT;
          shreg     <= fifo_dat;
          tx_data_r <= fifo_dat[HIT_WIDTH-1];
          tx_clk_r  <= 1'b0;
          div_cnt   <= '0;
          bit_cnt   <= BW'(HIT_WIDTH - 1);
        end
        TX_SHIFT: begin
          if (div_cnt == DIVW'(CLK_DIV - 1)) begin
            // End of a bit period: TX_CLK drops in the same cycle the data moves on.
            tx_clk_r <= 1'b0;
            div_cnt  <= '0;
            if (bit_cnt == '0) begin
              state     <= TX_IDLE;
              busy_r    <= 1'b0;
              tx_data_r <= 1'b0;
              shreg     <= '0;
            end else begin
              bit_cnt   <= bit_cnt - 1'b1;
              shreg     <= {shreg[HIT_WIDTH-2:0], 1'b0};
              tx_data_r <= shreg[HIT_WIDTH-2];
            end
          end else begin
            div_cnt  <= div_cnt + 1'b1;
            tx_clk_r <= (div_cnt >= DIVW'(HALF - 1));
          end
        end
        default: begin
          state     <= TX_IDLE;
          busy_r    <= 1'b0;
          tx_data_r <= 1'b0;
          tx_clk_r  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_DATA  = tx_data_r;
  assign TX_CLK   = tx_clk_r;
  assign BUSY     = busy_r;
  assign TX_TOKEN = token_r;

`ifdef MONO_DATA_TX_LOST_CNT_EN
  logic       hit_lost;
  logic [7:0] lost_cnt;

  assign hit_lost = HIT_WR & ~hit_acc;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lost_cnt <= '0;
    end else if (hit_lost && lost_cnt != 8'hFF) begin
      lost_cnt <= lost_cnt + 1'b1;
    end
  end

  assign LOST_CNT = lost_cnt;
`else
  assign LOST_CNT = '0;
`endif

endmodule

// File: tb/tb_mono_data_tx.sv
// Directed bench for mono_data_tx: serial framing, full/freeze drop rules, read-edge filtering, mid-transfer reset.
module tb_mono_data_tx;
  import mono_pkg::*;

`ifdef MONO_DATA_TX_LOST_CNT_EN
  localparam int LOST_EN = 1;
`else
  localparam int LOST_EN = 0;
`endif

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic        HIT_WR;
  logic [26:0] HIT_DATA;
  logic        HIT_FULL;
  logic        TX_TOKEN;
  logic        TX_DATA;
  logic        TX_CLK;
  logic        TX_READ;
  logic        TX_FREEZE;
  logic        BUSY;
  logic [7:0]  LOST_CNT;

  int tests = 0;
  int fails = 0;

  localparam logic [26:0] SIMUL_WORD = 27'h7ABCDEF;

  always #5 BUS_CLK = ~BUS_CLK;

  mono_data_tx #(.DEPTH(16), .CLK_DIV(4)) dut (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST   (BUS_RST),
    .HIT_WR    (HIT_WR),
    .HIT_DATA  (HIT_DATA),
    .HIT_FULL  (HIT_FULL),
    .TX_TOKEN  (TX_TOKEN),
    .TX_DATA   (TX_DATA),
    .TX_CLK    (TX_CLK),
    .TX_READ   (TX_READ),
    .TX_FREEZE (TX_FREEZE),
    .BUSY      (BUSY),
    .LOST_CNT  (LOST_CNT)
  );

  function automatic logic [26:0] wd(input int i);
    return 27'(32'h0123457 * i + 32'h15);
  endfunction

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic do_reset();
    BUS_RST = 1'b1; HIT_WR = 1'b0; TX_READ = 1'b0; TX_FREEZE = 1'b0; HIT_DATA = '0;
    tick(); tick();
    BUS_RST = 1'b0;
  endtask

  task automatic write_hit(input logic [26:0] d);
    HIT_DATA = d; HIT_WR = 1'b1;
    tick();
    HIT_WR = 1'b0;
  endtask

  // Raises TX_READ, optionally injects a second read edge / a hit write at given
  // sample indices, and records the bits seen on TX_CLK rising edges.
  task automatic run_transfer(input int edge2_k, input int wr_k, input logic [26:0] wr_dat,
                              output logic [26:0] word, output int nbits, output int busy_cyc,
                              output int load_k, output int rise_k, output int viol,
                              output logic full_after_wr, output bit timeout);
    logic prev_clk, prev_dat;
    bit   seen;
    word = '0; nbits = 0; busy_cyc = 0; load_k = -1; rise_k = -1; viol = 0;
    full_after_wr = 1'b0; timeout = 1'b1; prev_clk = 1'b0; prev_dat = 1'b0; seen = 1'b0;
    TX_READ = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (k == 1) TX_READ = 1'b0;
      if (edge2_k != 0 && k == edge2_k) TX_READ = 1'b1;
      if (edge2_k != 0 && k == edge2_k + 1) TX_READ = 1'b0;
      if (wr_k != 0 && k == wr_k) begin HIT_DATA = wr_dat; HIT_WR = 1'b1; end
      if (wr_k != 0 && k == wr_k + 1) begin HIT_WR = 1'b0; full_after_wr = HIT_FULL; end
      if (BUSY) begin
        busy_cyc++;
        if (load_k < 0) load_k = k;
        seen = 1'b1;
      end
      if (TX_CLK && !prev_clk) begin
        word = {word[25:0], TX_DATA};
        nbits++;
        if (rise_k < 0) rise_k = k;
      end
      if (TX_CLK && prev_clk && TX_DATA !== prev_dat) viol++;
      prev_clk = TX_CLK; prev_dat = TX_DATA;
      if (seen && !BUSY) begin timeout = 1'b0; break; end
    end
    TX_READ = 1'b0; HIT_WR = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (TX_TOKEN !== 1'b0) begin fails++; $display("FAIL reset_token got %b want 0", TX_TOKEN); end
    tests++; if (TX_DATA !== 1'b0)  begin fails++; $display("FAIL reset_tx_data got %b want 0", TX_DATA); end
    tests++; if (TX_CLK !== 1'b0)   begin fails++; $display("FAIL reset_tx_clk got %b want 0", TX_CLK); end
    tests++; if (BUSY !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", BUSY); end
    tests++; if (HIT_FULL !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", HIT_FULL); end
    tests++; if (LOST_CNT !== 8'd0) begin fails++; $display("FAIL reset_lost got %0d want 0", LOST_CNT); end
  endtask

  task automatic test_serial();
    logic [26:0] w; int nb, bc, lk, rk, vi; logic fa; bit to;
    do_reset();
    write_hit(pack_hit(6'h2D, 9'h05A, 6'h16, 6'h25));
    tests++; if (TX_TOKEN !== 1'b0) begin fails++; $display("FAIL serial_token_early got %b want 0", TX_TOKEN); end
    tick();
    tests++; if (TX_TOKEN !== 1'b1) begin fails++; $display("FAIL serial_token_up got %b want 1", TX_TOKEN); end
    run_transfer(0, 0, '0, w, nb, bc, lk, rk, vi, fa, to);
    tests++; if (to !== 1'b0)      begin fails++; $display("FAIL serial_timeout got %b want 0", to); end
    tests++; if (w !== 27'h5A5A5A5) begin fails++; $display("FAIL serial_word got %h want 5a5a5a5", w); end
    tests++; if (nb != 27)         begin fails++; $display("FAIL serial_nbits got %0d want 27", nb); end
    tests++; if (bc != 109)        begin fails++; $display("FAIL serial_busy_cycles got %0d want 109", bc); end
    tests++; if (lk != 1)          begin fails++; $display("FAIL serial_load_cycle got %0d want 1", lk); end
    tests++; if (rk != 4)          begin fails++; $display("FAIL serial_first_rise got %0d want 4", rk); end
    tests++; if (vi != 0)          begin fails++; $display("FAIL serial_data_while_clk_high got %0d want 0", vi); end
    tests++; if (TX_TOKEN !== 1'b0) begin fails++; $display("FAIL serial_token_down got %b want 0", TX_TOKEN); end
    tests++; if (TX_DATA !== 1'b0 || TX_CLK !== 1'b0) begin
      fails++; $display("FAIL serial_idle_lines got data=%b clk=%b want 0 0", TX_DATA, TX_CLK);
    end
  endtask

  task automatic test_full_and_simul();
    logic [26:0] w, exp_w; int nb, bc, lk, rk, vi, bad; logic fa; bit to;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      HIT_DATA = wd(i); HIT_WR = 1'b1;
      tick();
      if (i == 14) begin
        tests++; if (HIT_FULL !== 1'b0) begin fails++; $display("FAIL full_after15 got %b want 0", HIT_FULL); end
      end
      if (i == 15) begin
        tests++; if (HIT_FULL !== 1'b1) begin fails++; $display("FAIL full_after16 got %b want 1", HIT_FULL); end
      end
    end
    HIT_WR = 1'b0;
    tests++; if (LOST_CNT !== 8'(LOST_EN)) begin fails++; $display("FAIL full_lost got %0d want %0d", LOST_CNT, LOST_EN); end
    tests++; if (HIT_FULL !== 1'b1) begin fails++; $display("FAIL full_after17 got %b want 1", HIT_FULL); end
    // Insert a hit in the LOAD cycle, when the pop frees a slot.
    run_transfer(0, 1, SIMUL_WORD, w, nb, bc, lk, rk, vi, fa, to);
    tests++; if (to !== 1'b0 || w !== wd(0)) begin fails++; $display("FAIL simul_word got %h want %h (timeout %b)", w, wd(0), to); end
    tests++; if (fa !== 1'b1) begin fails++; $display("FAIL simul_full got %b want 1", fa); end
    tests++; if (LOST_CNT !== 8'(LOST_EN)) begin fails++; $display("FAIL simul_lost got %0d want %0d", LOST_CNT, LOST_EN); end
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      exp_w = (j < 15) ? wd(j + 1) : SIMUL_WORD;
      run_transfer(0, 0, '0, w, nb, bc, lk, rk, vi, fa, to);
      if (to || w !== exp_w || nb != 27) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL drain_order got %0d bad words want 0", bad); end
    tick();
    tests++; if (TX_TOKEN !== 1'b0 || HIT_FULL !== 1'b0) begin
      fails++; $display("FAIL drain_empty got token=%b full=%b want 0 0", TX_TOKEN, HIT_FULL);
    end
  endtask

  task automatic test_freeze();
    logic [26:0] w; int nb, bc, lk, rk, vi; logic fa; bit to;
    do_reset();
    write_hit(27'h1234567);
    tick();
    TX_FREEZE = 1'b1;
    write_hit(27'h0000001); write_hit(27'h0000002); write_hit(27'h0000003);
    tick();
    tests++; if (TX_TOKEN !== 1'b1) begin fails++; $display("FAIL freeze_token got %b want 1", TX_TOKEN); end
    tests++; if (LOST_CNT !== 8'(3 * LOST_EN)) begin fails++; $display("FAIL freeze_lost got %0d want %0d", LOST_CNT, 3 * LOST_EN); end
    run_transfer(0, 0, '0, w, nb, bc, lk, rk, vi, fa, to);
    tests++; if (to !== 1'b0 || w !== 27'h1234567) begin fails++; $display("FAIL freeze_word got %h want 1234567 (timeout %b)", w, to); end
    tests++; if (TX_TOKEN !== 1'b0) begin fails++; $display("FAIL freeze_fifo_unchanged got token=%b want 0", TX_TOKEN); end
    TX_FREEZE = 1'b0;
  endtask

  task automatic test_read_filter();
    logic [26:0] w; int nb, bc, lk, rk, vi; logic fa; bit to; bit busy_seen;
    do_reset();
    write_hit(27'h2AAAAAA); write_hit(27'h5555555);
    tick();
    run_transfer(50, 0, '0, w, nb, bc, lk, rk, vi, fa, to);
    tests++; if (to !== 1'b0 || w !== 27'h2AAAAAA) begin fails++; $display("FAIL ignore_word got %h want 2aaaaaa (timeout %b)", w, to); end
    tests++; if (bc != 109) begin fails++; $display("FAIL ignore_single_transfer got %0d busy cycles want 109", bc); end
    tests++; if (TX_TOKEN !== 1'b1) begin fails++; $display("FAIL ignore_one_left got token=%b want 1", TX_TOKEN); end
    run_transfer(0, 0, '0, w, nb, bc, lk, rk, vi, fa, to);
    tests++; if (to !== 1'b0 || w !== 27'h5555555) begin fails++; $display("FAIL ignore_second_word got %h want 5555555 (timeout %b)", w, to); end
    busy_seen = 1'b0;
    TX_READ = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) TX_READ = 1'b0;
      if (BUSY || TX_CLK) busy_seen = 1'b1;
    end
    tests++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL empty_read_busy got %b want 0", busy_seen); end
  endtask

  task automatic test_reset_mid();
    logic [26:0] a; int act;
    a = 27'h5A5A5A5;
    do_reset();
    write_hit(a); write_hit(27'h0F0F0F0);
    tick();
    TX_READ = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 1) TX_READ = 1'b0;
    end
    tests++; if (BUSY !== 1'b1 || TX_DATA !== a[10]) begin
      fails++; $display("FAIL midrst_bit10 got busy=%b data=%b want 1 %b", BUSY, TX_DATA, a[10]);
    end
    BUS_RST = 1'b1;
    tick();
    BUS_RST = 1'b0;
    tests++; if ({TX_DATA, TX_CLK, BUSY, TX_TOKEN, HIT_FULL} !== 5'b0) begin
      fails++; $display("FAIL midrst_outputs got data=%b clk=%b busy=%b token=%b full=%b want 0", TX_DATA, TX_CLK, BUSY, TX_TOKEN, HIT_FULL);
    end
    act = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) TX_READ = 1'b1;
      if (k == 4) TX_READ = 1'b0;
      tick();
      if (TX_CLK || TX_DATA || BUSY || TX_TOKEN) act++;
    end
    tests++; if (act != 0) begin fails++; $display("FAIL midrst_quiet got %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset();
    test_serial();
    test_full_and_simul();
    test_freeze();
    test_read_filter();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mono_data_tx.md
MONO_DATA_TX -- requirements
Module: mono_data_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning hit-buffer depth in words (power of two, 4..256).
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning BUS_CLK cycles per serial bit (even, >=2).
REQ-003 SHALL have port BUS_CLK  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port BUS_RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port HIT_WR  input  1  single-cycle hit insert strobe.
REQ-006 SHALL have port HIT_DATA  input  27  hit word {col[5:0], row[8:0], le[5:0], te[5:0]}.
REQ-007 SHALL have port HIT_FULL  output  1  buffer full.
REQ-008 SHALL have port TX_TOKEN  output  1  hit available to host.
REQ-009 SHALL have port TX_DATA  output  1  serial hit data, MSB first.
REQ-010 SHALL have port TX_CLK  output  1  serial clock; host samples TX_DATA on its rising edge.
REQ-011 SHALL have port TX_READ  input  1  host read request; rising edge starts one hit transfer.
REQ-012 SHALL have port TX_FREEZE  input  1  host freeze; blocks hit insertion.
REQ-013 SHALL have port BUSY  output  1  transfer in progress.
REQ-014 SHALL have port LOST_CNT  output  8  lost-hit counter.

Function
REQ-015 SHALL accept HIT_WR into the FIFO only when not full and TX_FREEZE low; otherwise the hit SHALL be dropped and counted lost.
REQ-016 SHALL drive TX_TOKEN registered, high one cycle after the FIFO becomes non-empty, low one cycle after it empties; TX_TOKEN SHALL ignore TX_FREEZE.
REQ-017 SHALL detect a TX_READ rising edge with a one-cycle edge-detect register; an edge while BUSY or FIFO empty SHALL be ignored.
REQ-018 SHALL implement FSM IDLE -> LOAD -> SHIFT -> IDLE: IDLE->LOAD on accepted edge; LOAD pops one word into a 27-bit shift register (one cycle); SHIFT emits 27 bits; return to IDLE after bit 0's full period.
REQ-019 SHALL hold each bit on TX_DATA for CLK_DIV cycles: TX_CLK low for the first CLK_DIV/2, high for the second CLK_DIV/2; TX_DATA changes only while TX_CLK low.
REQ-020 SHALL present the first bit (bit 26) two cycles after the cycle in which the edge is registered; a transfer lasts 27*CLK_DIV cycles in SHIFT.
REQ-021 SHALL assert BUSY from LOAD through the last SHIFT cycle, inclusive.
REQ-022 SHALL drive TX_DATA and TX_CLK low in IDLE and LOAD.
REQ-023 SHALL permit a simultaneous insert and pop in the same cycle; occupancy unchanged; when full, a pop in the same cycle SHALL make room for that cycle's insert.
REQ-024 SHALL assert HIT_FULL combinationally from occupancy == DEPTH.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH with an extra MSB for full/empty.

Reset
REQ-026 SHALL on BUS_RST clear FIFO, FSM to IDLE, shift register, edge register, LOST_CNT to 0; outputs TX_TOKEN, TX_DATA, TX_CLK, BUSY, HIT_FULL SHALL be 0 the cycle after.
REQ-027 SHALL abort a transfer in progress on BUS_RST, with no partial bits afterwards.

Configuration
REQ-028 SHALL, with MONO_DATA_TX_LOST_CNT_EN defined, implement LOST_CNT as an 8-bit counter incrementing per dropped hit, saturating at 255.
REQ-029 SHALL, without MONO_DATA_TX_LOST_CNT_EN, tie LOST_CNT to 0 and synthesize no counter logic.

Structure
REQ-030 SHALL take HIT_WIDTH (27) and field offsets/widths for col, row, le, te from shared package mono_pkg.
REQ-031 SHALL place the buffer in sub-module mono_data_tx_fifo (synchronous FIFO, DEPTH-parameterised, push/pop/full/empty/count).

Verification
REQ-032 SHALL cover: reset, write 0x5A5A5A5, READ pulse -> TOKEN high, 27 bits 101_1010_0101_1010_0101_1010_0101 on TX_CLK rising edges, 108 SHIFT cycles with CLK_DIV=4, then TOKEN low.
REQ-033 SHALL cover: 17 writes with DEPTH=16 -> HIT_FULL high after 16th, LOST_CNT=1 (0 when macro undefined).
REQ-034 SHALL cover: TX_FREEZE high, 3 writes -> FIFO unchanged, LOST_CNT=3; TOKEN unaffected.
REQ-035 SHALL cover: second READ edge mid-transfer -> ignored, exactly one word popped; READ with empty FIFO -> BUSY stays 0.
REQ-036 SHALL cover: BUS_RST at bit 10 of a transfer -> TX_DATA/TX_CLK/BUSY/TOKEN 0 next cycle, FIFO empty.
REQ-037 SHALL cover: full FIFO, simultaneous pop and HIT_WR -> no loss, occupancy stays 16.
